// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and the
// pipeline stage registers built on if_id_reg.
package fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_DROP
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            valid;
   } if_id_t;

   localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// Pipeline stage register with flush, stall and load; a flush wins over a
// stall, and a cycle with nothing to load leaves a bubble behind.
module if_id_reg
   import fetch_pkg::*;
(
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_flush,
   input  logic   i_stall,
   input  logic   i_load,
   input  if_id_t i_load_data,
   output if_id_t o_stage
);

   if_id_t stage_d;
   if_id_t stage_q;

   always_comb begin
      stage_d = IF_ID_BUBBLE;
      if (i_flush) begin
         stage_d = IF_ID_BUBBLE;
      end else if (i_stall) begin
         stage_d = stage_q;
      end else if (i_load) begin
         stage_d = i_load_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stage_q <= IF_ID_BUBBLE;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign o_stage = stage_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem
// request port and feeds the IF/ID register through a one-entry hold buffer.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          XLEN     = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_stall_pc,
   input  logic            i_stall_if_id,
   input  logic            i_flush_if_id,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [XLEN-1:0] i_imem_rdata,
   output logic [XLEN-1:0] o_pc_id,
   output logic [XLEN-1:0] o_instr_id,
   output logic            o_valid_id
);

   fetch_state_e    state_d, state_q;
   logic [XLEN-1:0] pc_d, pc_q;
   logic [XLEN-1:0] req_pc_d, req_pc_q;
   if_id_t          hold_d, hold_q;

   logic            handshake;
   logic            live_rsp;
   logic            if_id_flush;
   logic            if_id_load;
   logic [XLEN-1:0] redirect_target;
   if_id_t          if_id_load_data;
   if_id_t          if_id;

   // Reset gates the request so the port stays quiet while reset is held.
   assign o_imem_req      = i_rst_n && (state_q == S_REQ) && !hold_q.valid
                            && !i_stall_pc && !i_redirect_valid;
   assign o_imem_addr     = pc_q;
   assign handshake       = o_imem_req && i_imem_gnt;
   assign live_rsp        = (state_q == S_WAIT) && i_imem_rvalid && !i_redirect_valid;
   assign redirect_target = i_redirect_pc & ~XLEN'(3);

   assign if_id_flush     = i_flush_if_id || i_redirect_valid;
   assign if_id_load      = hold_q.valid || live_rsp;
   assign if_id_load_data = hold_q.valid ? hold_q
                                         : '{pc: req_pc_q, instr: i_imem_rdata, valid: 1'b1};

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      req_pc_d = req_pc_q;
      hold_d   = hold_q;

      unique case (state_q)
         S_REQ: begin
            if (handshake) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + XLEN'(4);
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (i_imem_rvalid) begin
               state_d = S_REQ;
            end else if (i_redirect_valid) begin
               state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (i_imem_rvalid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      // A stalled IF/ID parks the live response; an unstalled, unflushed one drains it.
      if (live_rsp && i_stall_if_id) begin
         hold_d = '{pc: req_pc_q, instr: i_imem_rdata, valid: 1'b1};
      end else if (hold_q.valid && !i_stall_if_id && !if_id_flush) begin
         hold_d.valid = 1'b0;
      end

      if (i_redirect_valid) begin
         pc_d         = redirect_target;
         hold_d.valid = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_REQ;
         pc_q     <= RESET_PC;
         req_pc_q <= '0;
         hold_q   <= IF_ID_BUBBLE;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         req_pc_q <= req_pc_d;
         hold_q   <= hold_d;
      end
   end

   if_id_reg u_if_id_reg (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_flush     (if_id_flush),
      .i_stall     (i_stall_if_id),
      .i_load      (if_id_load),
      .i_load_data (if_id_load_data),
      .o_stage     (if_id)
   );

   assign o_pc_id    = if_id.pc;
   assign o_instr_id = if_id.instr;
   assign o_valid_id = if_id.valid;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage for the pipelined RV32I core. It owns the PC, drives a request/grant/response instruction-memory port with a single outstanding request, and loads the IF/ID pipeline register.
- It consumes the stall, flush and redirect controls produced by the hazard/forwarding logic and the EX-stage branch resolution.
- A one-entry hold buffer absorbs a fetch response that returns while IF/ID is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- XLEN, 32, address and instruction width; only 32 is supported.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_stall_pc  in  1  hazard: do not issue a new fetch this cycle
- i_stall_if_id  in  1  hazard: IF/ID register holds its value
- i_flush_if_id  in  1  hazard: IF/ID becomes a bubble
- i_redirect_valid  in  1  branch/jump taken in EX
- i_redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0
- o_imem_req  out  1  fetch request (combinational from state)
- o_imem_addr  out  32  fetch address, the current PC
- i_imem_gnt  in  1  memory accepts the request this cycle
- i_imem_rvalid  in  1  response valid; earliest one cycle after the grant; responses return in order
- i_imem_rdata  in  32  fetched instruction
- o_pc_id  out  32  IF/ID PC
- o_instr_id  out  32  IF/ID instruction
- o_valid_id  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, i_rst_n=0):
  - pc=RESET_PC, state=S_REQ, hold buffer empty.
  - o_valid_id=0, o_instr_id=32'h0000_0013 (NOP), o_pc_id=0, o_imem_req=0.
  - The first request is asserted in the first cycle after reset is released.
- FSM states:
  - S_REQ: no request outstanding.
  - S_WAIT: one request outstanding; its response is live.
  - S_DROP: one request outstanding; its response must be discarded.
- o_imem_req = (state==S_REQ) && !hold_valid && !i_stall_pc && !i_redirect_valid. o_imem_addr = pc.
- Handshake is req&&gnt. On handshake: req_pc<=pc, pc<=pc+4 (wraps modulo 2^32), state<=S_WAIT. Without a grant, req stays high and the address stays stable.
- S_WAIT with rvalid:
  - No redirect: the response {req_pc, rdata} is delivered to IF/ID if !i_stall_if_id, otherwise written to the hold buffer. state<=S_REQ.
  - With redirect: the response is discarded and state<=S_REQ.
- S_WAIT with redirect and no rvalid: state<=S_DROP.
- S_DROP with rvalid: the response is discarded and state<=S_REQ. A redirect while in S_DROP keeps S_DROP.
- Redirect (highest priority):
  - pc<={i_redirect_pc[31:2],2'b00}.
  - Hold buffer cleared.
  - No request is issued in that cycle.
- IF/ID update, in priority order:
  1. i_flush_if_id or i_redirect_valid: valid=0, instr=NOP, pc=0. Flush overrides stall.
  2. i_stall_if_id: hold the current value.
  3. hold_valid: load the hold entry and clear the hold buffer.
  4. Live response this cycle: load it.
  5. Otherwise: bubble (valid=0, instr=NOP).
- hold_valid blocks new requests, so the hold buffer and a live response never coexist.
- Throughput: at most one instruction per 2 cycles (one outstanding request, response latency of at least 1).
- i_stall_pc only gates issue. An already-outstanding response is still accepted.

Decomposition:
- fetch_pkg holds:
  - XLEN
  - NOP_INSTR = 32'h0000_0013
  - the fetch_state_e enum {S_REQ, S_WAIT, S_DROP}
  - the if_id_t struct {pc, instr, valid}
- One sub-module, if_id_reg: the flush/stall/load pipeline register with async reset. It is reused by the other stage registers.
- The FSM, PC and hold buffer stay in fetch_unit.

Test Plan:
- Reset release with gnt=1 and rvalid one cycle after each grant: o_imem_addr steps 0x0, 0x4, 0x8. IF/ID shows pc 0x0/instr A with valid=1, then pc 0x4/instr B; valid=0 between instructions.
- Grant withheld for 3 cycles: o_imem_req stays 1 with o_imem_addr=0x4 held constant. No IF/ID update; it shows a bubble.
- Response arrives while i_stall_if_id=1 for 2 cycles: the response lands in the hold buffer and o_imem_req=0. On stall release, IF/ID loads the held {0x8, C}, then fetching resumes at 0xC.
- Redirect to 0x100 while in S_WAIT; the stale response arrives 2 cycles later: the stale response is dropped, IF/ID is flushed (valid=0, NOP), and the next o_imem_addr is 0x100.
- Redirect to 0x203 in the same cycle as rvalid: the response is dropped, the next request goes to 0x200, and o_imem_req=0 in the redirect cycle.
- i_rst_n asserted mid-S_WAIT, then the old rvalid pulses after release: all outputs return to their reset values immediately. The FSM is in S_REQ, so the pulse is ignored, and the first request goes to RESET_PC.
